// File: rtl/lmsm_sequencer_if.sv
// Controller/datapath bundle for the LM/SM sequencer: launch, status, RF port and memory port.
// master = the sequencer itself; slave = the controller, register file and memory around it.
interface lmsm_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              start;
  logic              is_store;
  logic [7:0]        reg_mask;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic [3:0]        xfer_count;
  logic [2:0]        rf_radd;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_wen;
  logic [2:0]        rf_wadd;
  logic [DATA_W-1:0] rf_wdata;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  start, is_store, reg_mask, base_addr, rf_rdata, mem_rdata, mem_ready,
    output busy, done, xfer_count, rf_radd, rf_wen, rf_wadd, rf_wdata,
           mem_ren, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output start, is_store, reg_mask, base_addr, rf_rdata, mem_rdata, mem_ready,
    input  busy, done, xfer_count, rf_radd, rf_wen, rf_wadd, rf_wdata,
           mem_ren, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: one memory access per set mask bit, lowest bit first, consecutive addresses.
// Done after 2n+1 (SM) / 3n+1 (LM) cycles with ready high; a request holds in ACCESS until mem_ready.
module lmsm_sequencer #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int ADDR_STEP = 1
) (
  input logic              clk,
  input logic              proc_rst,
  lmsm_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, SCAN, ACCESS, WRITE, DONE} state_t;

  state_t            state;
  logic [7:0]        mask_q;
  logic [ADDR_W-1:0] base_q;
  logic              store_q;
  logic [3:0]        count_q;
  logic              busy_q;
  logic              done_q;
  logic              mem_ren_q;
  logic              mem_wen_q;
  logic              rf_wen_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic [2:0]        idx;
  logic [7:0]        mask_clr;
  logic              last_xfer;

  // Highest index is visited first so the lowest set bit wins.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) idx = 3'(i);
    end
  end

  assign mask_clr  = mask_q & ~(8'd1 << idx);
  assign last_xfer = (mask_clr == 8'd0);

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.xfer_count = count_q;
  assign bus.rf_radd    = idx;
  assign bus.rf_wadd    = idx;
  assign bus.rf_wen     = rf_wen_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_addr   = base_q + ADDR_W'(ADDR_STEP) * ADDR_W'(count_q);

  // Falling-edge state updates keep this block in step with the controller.
  always_ff @(negedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      base_q      <= '0;
      store_q     <= 1'b0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      rf_wen_q    <= 1'b0;
      mem_wdata_q <= '0;
      rf_wdata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask_q  <= bus.reg_mask;
            base_q  <= bus.base_addr;
            store_q <= bus.is_store;
            count_q <= '0;
            if (bus.reg_mask == 8'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= SCAN;
              busy_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          mem_wdata_q <= bus.rf_rdata;
          mem_wen_q   <= store_q;
          mem_ren_q   <= ~store_q;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (bus.mem_ready) begin
            mem_wen_q <= 1'b0;
            mem_ren_q <= 1'b0;
            if (store_q) begin
              mask_q  <= mask_clr;
              count_q <= count_q + 4'd1;
              if (last_xfer) begin
                state  <= DONE;
                done_q <= 1'b1;
                busy_q <= 1'b0;
              end else begin
                state <= SCAN;
              end
            end else begin
              rf_wdata_q <= bus.mem_rdata;
              rf_wen_q   <= 1'b1;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          rf_wen_q <= 1'b0;
          mask_q   <= mask_clr;
          count_q  <= count_q + 4'd1;
          if (last_xfer) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state <= SCAN;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: RF/memory models, transfer scoreboard, table of launches plus a reset sequence.
module tb_lmsm_sequencer;

  logic clk = 1'b0;
  logic proc_rst;
  always #5 clk = ~clk;

  lmsm_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  lmsm_sequencer dut (.clk(clk), .proc_rst(proc_rst), .bus(bus));

  logic [15:0] mem_m [0:65535];
  logic [15:0] rf_m  [0:7];

  assign bus.rf_rdata  = rf_m[bus.rf_radd];
  assign bus.mem_rdata = mem_m[bus.mem_addr];

  typedef struct {
    logic        kind;   // 1 = memory write, 0 = RF write
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;

  typedef struct {
    logic        st;
    logic [7:0]  mask;
    logic [15:0] base;
    int          ready_from;
    int          exp_done;
    logic        mid_start;
    logic        hold;
  } vec_t;

  sb_t sb_q[$];
  sb_t e;
  int  n_pass = 0;
  int  n_chk  = 0;
  int  req_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.busy, bus.done, bus.xfer_count, bus.rf_radd, bus.rf_wen, bus.rf_wadd,
                bus.rf_wdata, bus.mem_ren, bus.mem_wen, bus.mem_addr, bus.mem_wdata});
  endfunction

  // Sees inputs driven at posedge+1 and outputs from the last falling edge.
  always @(posedge clk) begin
    #3;
    if (!proc_rst) begin
      if (bus.mem_ren || bus.mem_wen)
        check("req_exclusive", 64'(bus.mem_ren & bus.mem_wen), 64'(0));
      if ((bus.mem_ren || bus.mem_wen) && bus.mem_ready) req_cnt++;
      if (bus.mem_wen && bus.mem_ready) begin
        if (sb_q.size() == 0) check("sb_unexpected_mem_write", 64'(1), 64'(0));
        else begin
          e = sb_q.pop_front();
          check("sb_mem_write", 64'({1'b1, bus.mem_addr, bus.mem_wdata}),
                64'({e.kind, e.addr, e.data}));
        end
        mem_m[bus.mem_addr] = bus.mem_wdata;
      end
      if (bus.rf_wen) begin
        if (sb_q.size() == 0) check("sb_unexpected_rf_write", 64'(1), 64'(0));
        else begin
          e = sb_q.pop_front();
          check("sb_rf_write", 64'({1'b0, 13'd0, bus.rf_wadd, bus.rf_wdata}),
                64'({e.kind, e.addr, e.data}));
        end
        rf_m[bus.rf_wadd] = bus.rf_wdata;
      end
    end
  end

  task automatic run_op(input int id, input vec_t v);
    int          got = 0;
    int          busy_cnt = 0;
    int          rfw_cyc = 0;
    int          req0;
    int          j = 0;
    logic [3:0]  cnt_at_done = '0;
    logic [15:0] a;
    logic [15:0] hold_data = '0;
    logic        first = 1'b1;
    sb_t         s;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      if (v.mask[i]) begin
        a = v.base + 16'(j);
        s.kind = v.st;
        s.addr = v.st ? a : 16'(i);
        s.data = v.st ? rf_m[i] : mem_m[a];
        if (first) hold_data = rf_m[i];
        first = 1'b0;
        sb_q.push_back(s);
        j++;
      end
    end
    bus.start     = 1'b1;
    bus.is_store  = v.st;
    bus.reg_mask  = v.mask;
    bus.base_addr = v.base;
    bus.mem_ready = (v.ready_from <= 1);
    req0 = req_cnt;
    for (int k = 1; k <= 60 && got == 0; k++) begin
      @(posedge clk); #1;
      bus.start = v.mid_start && (k == 3);
      if (k == 1) begin
        bus.reg_mask  = ~v.mask;
        bus.is_store  = ~v.st;
        bus.base_addr = ~v.base;
      end
      bus.mem_ready = (k >= v.ready_from);
      if (bus.busy) busy_cnt++;
      if (bus.rf_wen) rfw_cyc++;
      if (v.hold && k >= 2 && k <= 5)
        check($sformatf("v%0d_hold_k%0d", id, k), 64'({bus.mem_wen, bus.mem_addr, bus.mem_wdata}),
              64'({1'b1, v.base, hold_data}));
      if (bus.done) begin
        got = k;
        cnt_at_done = bus.xfer_count;
      end
    end
    bus.start = 1'b0;
    check($sformatf("v%0d_done_cycle", id), 64'(got), 64'(v.exp_done));
    check($sformatf("v%0d_xfer_count", id), 64'(cnt_at_done), 64'($countones(v.mask)));
    check($sformatf("v%0d_busy_cycles", id), 64'(busy_cnt),
          64'((v.mask != 0) ? v.exp_done - 1 : 0));
    check($sformatf("v%0d_rf_wen_cycles", id), 64'(rfw_cyc),
          64'(v.st ? 0 : $countones(v.mask)));
    check($sformatf("v%0d_mem_requests", id), 64'(req_cnt - req0), 64'($countones(v.mask)));
    check($sformatf("v%0d_sb_drained", id), 64'(sb_q.size()), 64'(0));
    sb_q.delete();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check($sformatf("v%0d_idle_after_%0d", id, k),
            64'({bus.busy, bus.done, bus.mem_ren, bus.mem_wen, bus.rf_wen}), 64'(0));
    end
  endtask

  vec_t vecs [8];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 8'h81, 16'h0010, 1, 5,  1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h05, 16'h0040, 1, 7,  1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 16'h0000, 1, 1,  1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h00, 16'h0000, 1, 1,  1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h02, 16'h0020, 5, 6,  1'b0, 1'b1};
    vecs[5] = '{1'b0, 8'h03, 16'hFFFF, 1, 7,  1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'hFF, 16'h0100, 1, 17, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 8'hA0, 16'h0200, 1, 7,  1'b0, 1'b0};

    for (int i = 0; i < 65536; i++) mem_m[i] = 16'(i) ^ 16'h5A5A;
    mem_m[16'h0040] = 16'hAAAA;
    mem_m[16'h0041] = 16'h5555;
    mem_m[16'hFFFF] = 16'h1111;
    mem_m[16'h0000] = 16'h2222;
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0100 * 16'(i) + 16'h0011;
    rf_m[0] = 16'h1234;
    rf_m[1] = 16'hC0DE;
    rf_m[7] = 16'hBEEF;

    proc_rst      = 1'b1;
    bus.start     = 1'b0;
    bus.is_store  = 1'b0;
    bus.reg_mask  = 8'h00;
    bus.base_addr = 16'h0000;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 64'(0));
    proc_rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(i, vecs[i]);

    check("sm_mem_0x10", 64'(mem_m[16'h0010]), 64'(16'h1234));
    check("sm_mem_0x11", 64'(mem_m[16'h0011]), 64'(16'hBEEF));
    check("lm_r2", 64'(rf_m[2]), 64'(16'h5555));
    check("wrap_r0_from_ffff", 64'(rf_m[0]), 64'(16'h1111));
    check("wrap_r1_from_0000", 64'(rf_m[1]), 64'(16'h2222));

    // Reset asserted mid-ACCESS with the write still stalled.
    rf_m[0] = 16'h7777;
    mem_m[16'h0030] = 16'hDEAD;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.is_store  = 1'b1;
    bus.reg_mask  = 8'h01;
    bus.base_addr = 16'h0030;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_access", 64'({bus.mem_wen, bus.mem_addr, bus.mem_wdata}),
          64'({1'b1, 16'h0030, 16'h7777}));
    proc_rst = 1'b1;
    #1;
    check("rst_immediate_zero", outs(), 64'(0));
    bus.mem_ready = 1'b1;
    @(negedge clk); #2;
    check("rst_held_zero", outs(), 64'(0));
    @(posedge clk); #1;
    proc_rst = 1'b0;
    @(posedge clk); #1;
    check("rst_no_write", 64'(mem_m[16'h0030]), 64'(16'hDEAD));
    check("rst_idle_after", outs(), 64'(0));
    rv = '{1'b1, 8'h01, 16'h0030, 1, 3, 1'b0, 1'b0};
    run_op(8, rv);
    check("post_rst_sm_write", 64'(mem_m[16'h0030]), 64'(16'h7777));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
